// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
//   Multi-port integer register file for a superscalar decode stage. It
//   provides NRD combinational read ports with write-through bypass from NWR
//   writeback ports. A per-register pending bit (a scoreboard) lets decode
//   stall on RAW hazards without any external logic.
//
// Parameters
//   WIDTH  data width per register
//   NREGS  number of architectural registers; register 0 reads as zero
//   NRD    number of read ports
//   NWR    number of writeback ports; a higher index is younger and wins
//   AW     address width, derived from NREGS
//
// Ports
//   clk       clock
//   rst       synchronous, active-high reset; overrides every other input
//   wr_en     per-port write enable
//   wr_addr   per-port destination, port i at [i*AW +: AW]
//   wr_data   per-port write data, port i at [i*WIDTH +: WIDTH]
//   rd_addr   per-port source address, port j at [j*AW +: AW]
//   rd_data   per-port read data (combinational, bypassed)
//   rd_busy   source has an in-flight producer not being written this cycle
//   iss_en    decode allocates iss_dest as a new in-flight destination
//   iss_dest  destination being allocated
//   flush     clear all pending bits; register writes still take effect
//   pend_cnt  registered count of pending registers

module regfile_mp_sb #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 4,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NWR-1:0]     wr_en,
  input  logic [NWR*AW-1:0]  wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic [NRD*AW-1:0]  rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]     rd_busy,
  input  logic               iss_en,
  input  logic [AW-1:0]      iss_dest,
  input  logic               flush,
  output logic [AW:0]        pend_cnt
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic [AW:0]      cnt_nxt;

  // Register storage. Ports are visited in ascending order, so the last
  // non-blocking assignment (the youngest port) wins an address conflict.
  // Register 0 is never written and stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && (wr_addr[i*AW +: AW] != '0)) begin
          regs[wr_addr[i*AW +: AW]] <= wr_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Next scoreboard state. Writebacks clear their destination bits first.
  // An issue then sets its destination, so a younger producer that is issued
  // in the same cycle as an older writeback keeps the register pending.
  // A flush clears everything, including that cycle's issue.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i] && (wr_addr[i*AW +: AW] != '0)) begin
        pending_nxt[wr_addr[i*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en && (iss_dest != '0)) begin
      pending_nxt[iss_dest] = 1'b1;
    end
    if (flush) begin
      pending_nxt = '0;
    end
    pending_nxt[0] = 1'b0;
  end

  // The count is computed from the next state so that it changes in the same
  // cycle as the pending bits it summarises.
  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, pending_nxt[r]};
    end
  end

  // Scoreboard and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  // Read ports. Bypass comes from the youngest matching writeback. A
  // same-cycle writeback also hides the pending bit, because the consumer
  // picks up the value through the bypass and does not need to stall.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < NRD; j++) begin
      logic [AW-1:0]    ra;
      logic [WIDTH-1:0] val;
      logic             busy;
      ra   = rd_addr[j*AW +: AW];
      val  = regs[ra];
      busy = pending[ra];
      for (int i = 0; i < NWR; i++) begin
        if (wr_en[i] && (wr_addr[i*AW +: AW] == ra)) begin
          val  = wr_data[i*WIDTH +: WIDTH];
          busy = 1'b0;
        end
      end
      if (ra == '0) begin
        val  = '0;
        busy = 1'b0;
      end
      rd_data[j*WIDTH +: WIDTH] = val;
      rd_busy[j]                = busy;
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb
//   Directed testbench for regfile_mp_sb with the default parameters
//   (32 x 32-bit registers, 4 read ports, 2 write ports). Expected values
//   are written out by hand next to each stimulus.

module tb_regfile_mp_sb;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 4;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                 clk;
  logic                 rst;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*WIDTH-1:0] wr_data;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 iss_en;
  logic [AW-1:0]        iss_dest;
  logic                 flush;
  logic [AW:0]          pend_cnt;

  int checks = 0;
  int errors = 0;

  regfile_mp_sb #(
    .WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_dest(iss_dest), .flush(flush),
    .pend_cnt(pend_cnt)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives all read addresses.
  task automatic applyStimulus(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    rd_addr = {a3, a2, a1, a0};
    #1;
  endtask

  // Drives a single write port; other write ports are left unchanged.
  task automatic setWrite(input int port, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d);
    wr_en[port]                  = 1'b1;
    wr_addr[port*AW +: AW]       = a;
    wr_data[port*WIDTH +: WIDTH] = d;
  endtask

  // Advances one clock edge and then returns all strobes to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    wr_en  = '0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rdPort(input int j);
    return rd_data[j*WIDTH +: WIDTH];
  endfunction

  initial begin
    rst      = 1'b1;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    iss_en   = 1'b0;
    iss_dest = '0;
    flush    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // 1. Reset state: every register reads zero and is not busy.
    for (int base = 1; base < NREGS; base += 4) begin
      applyStimulus(AW'(base), AW'((base + 1) % NREGS), AW'((base + 2) % NREGS),
                    AW'((base + 3) % NREGS));
      for (int j = 0; j < NRD; j++) begin
        checkOutput($sformatf("rst_data_x%0d", (base + j) % NREGS), rdPort(j), 32'h0);
        checkOutput($sformatf("rst_busy_x%0d", (base + j) % NREGS),
                    {31'b0, rd_busy[j]}, 32'h0);
      end
    end
    checkOutput("rst_pend_cnt", {26'b0, pend_cnt}, 32'h0);

    // 2. Conflicting writes to x5: port 1 is younger and wins, for both
    //    the bypass and the stored value.
    setWrite(0, 5'd5, 32'hAAAA);
    setWrite(1, 5'd5, 32'hBBBB);
    applyStimulus(5'd5, 5'd0, 5'd1, 5'd5);
    checkOutput("wr_conflict_bypass", rdPort(0), 32'hBBBB);
    checkOutput("wr_conflict_bypass_p3", rdPort(3), 32'hBBBB);
    checkOutput("wr_conflict_x1_unaff", rdPort(2), 32'h0);
    tick();
    applyStimulus(5'd5, 5'd0, 5'd1, 5'd2);
    checkOutput("wr_conflict_stored", rdPort(0), 32'hBBBB);
    checkOutput("wr_nonpend_cnt", {26'b0, pend_cnt}, 32'h0);

    // 3. Issue x7, stall on it, then release it with a writeback.
    iss_en   = 1'b1;
    iss_dest = 5'd7;
    applyStimulus(5'd7, 5'd0, 5'd0, 5'd0);
    checkOutput("iss_same_cycle_busy", {31'b0, rd_busy[0]}, 32'h0);
    tick();
    applyStimulus(5'd7, 5'd0, 5'd0, 5'd0);
    checkOutput("iss_busy_x7", {31'b0, rd_busy[0]}, 32'h1);
    checkOutput("iss_pend_cnt1", {26'b0, pend_cnt}, 32'h1);
    setWrite(0, 5'd7, 32'h1234);
    applyStimulus(5'd0, 5'd7, 5'd0, 5'd0);
    checkOutput("wb_release_busy", {31'b0, rd_busy[1]}, 32'h0);
    checkOutput("wb_bypass_data", rdPort(1), 32'h1234);
    checkOutput("wb_cnt_still1", {26'b0, pend_cnt}, 32'h1);
    tick();
    applyStimulus(5'd0, 5'd7, 5'd0, 5'd0);
    checkOutput("wb_cnt0", {26'b0, pend_cnt}, 32'h0);
    checkOutput("wb_busy_clear", {31'b0, rd_busy[1]}, 32'h0);
    checkOutput("wb_stored", rdPort(1), 32'h1234);

    // 4. x9 pending, then a re-issue and a writeback in the same cycle.
    //    The set wins, so x9 stays pending while its data is updated.
    iss_en   = 1'b1;
    iss_dest = 5'd9;
    tick();
    iss_en   = 1'b1;
    iss_dest = 5'd9;
    setWrite(1, 5'd9, 32'h5555);
    applyStimulus(5'd0, 5'd0, 5'd9, 5'd0);
    checkOutput("setclr_same_busy", {31'b0, rd_busy[2]}, 32'h0);
    tick();
    applyStimulus(5'd0, 5'd0, 5'd9, 5'd0);
    checkOutput("setclr_busy", {31'b0, rd_busy[2]}, 32'h1);
    checkOutput("setclr_data", rdPort(2), 32'h5555);
    checkOutput("setclr_cnt", {26'b0, pend_cnt}, 32'h1);
    setWrite(0, 5'd9, 32'h6666);
    tick();
    checkOutput("x9_retired_cnt", {26'b0, pend_cnt}, 32'h0);

    // 5. Three in-flight destinations, then a flush that overrides an issue.
    for (int d = 3; d <= 5; d++) begin
      iss_en   = 1'b1;
      iss_dest = AW'(d);
      tick();
    end
    applyStimulus(5'd3, 5'd4, 5'd5, 5'd6);
    checkOutput("three_pend_cnt", {26'b0, pend_cnt}, 32'h3);
    checkOutput("three_busy", {28'b0, rd_busy}, 32'h7);
    flush    = 1'b1;
    iss_en   = 1'b1;
    iss_dest = 5'd6;
    tick();
    applyStimulus(5'd3, 5'd4, 5'd5, 5'd6);
    checkOutput("flush_busy", {28'b0, rd_busy}, 32'h0);
    checkOutput("flush_cnt", {26'b0, pend_cnt}, 32'h0);

    // 6. Register 0 ignores writes and issues; pend_cnt keeps counting x10.
    iss_en   = 1'b1;
    iss_dest = 5'd10;
    tick();
    setWrite(0, 5'd0, 32'hFFFF);
    iss_en   = 1'b1;
    iss_dest = 5'd0;
    applyStimulus(5'd0, 5'd10, 5'd0, 5'd0);
    checkOutput("x0_bypass", rdPort(0), 32'h0);
    checkOutput("x0_busy_same", {31'b0, rd_busy[0]}, 32'h0);
    tick();
    applyStimulus(5'd0, 5'd10, 5'd0, 5'd0);
    checkOutput("x0_data", rdPort(0), 32'h0);
    checkOutput("x0_busy", {31'b0, rd_busy[0]}, 32'h0);
    checkOutput("x0_cnt_unchanged", {26'b0, pend_cnt}, 32'h1);
    checkOutput("x10_busy", {31'b0, rd_busy[1]}, 32'h1);

    // 7. Reset with a write and an issue in flight discards everything.
    rst      = 1'b1;
    setWrite(0, 5'd11, 32'hCAFE);
    iss_en   = 1'b1;
    iss_dest = 5'd12;
    tick();
    rst = 1'b0;
    applyStimulus(5'd5, 5'd11, 5'd10, 5'd12);
    checkOutput("rst2_x5", rdPort(0), 32'h0);
    checkOutput("rst2_x11", rdPort(1), 32'h0);
    checkOutput("rst2_busy", {28'b0, rd_busy}, 32'h0);
    checkOutput("rst2_cnt", {26'b0, pend_cnt}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
